// File: rtl/int_ack_ctrl_pkg.sv
// Shared types and constants for the interrupt acknowledge controller.
package int_ack_ctrl_pkg;

    localparam int unsigned INT_DEPTH_W = 3;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned ACK_CNT_W   = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PEND   = 3'd1,
        TAKE   = 3'd2,
        ACK    = 3'd3,
        SETTLE = 3'd4
    } int_ack_state_t;

endpackage

// File: rtl/int_ack_ctrl_if.sv
// Core/chain handshake bundle for int_ack_ctrl.
//   irq, int_en, boundary, take_ack, ret : toward the controller
//   take, ack (active low), iei_root, depth : from the controller
interface int_ack_ctrl_if;
    import int_ack_ctrl_pkg::*;

    logic                   irq;
    logic                   int_en;
    logic                   boundary;
    logic                   take_ack;
    logic                   ret;
    logic                   take;
    logic                   ack;
    logic                   iei_root;
    logic [INT_DEPTH_W-1:0] depth;

    modport slave (
        input  irq, int_en, boundary, take_ack, ret,
        output take, ack, iei_root, depth
    );

    modport master (
        output irq, int_en, boundary, take_ack, ret,
        input  take, ack, iei_root, depth
    );

endinterface

// File: rtl/int_ack_ctrl_sync2.sv
// Generic two-flop synchronizer for asynchronous single-bit pins.
//   clk, rst : clock, asynchronous active-high reset (output resets to 0)
//   d        : asynchronous input
//   q        : synchronized output, SYNC_STAGES edges behind d
module sync2
    import int_ack_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/int_ack_ctrl.sv
// CPU-side root of the interrupt daisy chain: synchronizes irq, requests entry
// at an instruction boundary, strobes the active-low ack, and tracks in-service
// depth between entry and ret, masking the chain root when full.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : int_ack_ctrl_if.slave (irq/int_en/boundary/take_ack/ret in;
//              take/ack/iei_root/depth out, all registered)
// Build option: define INT_ACK_CTRL_NEST_EN to allow nested entries up to
// NEST_DEPTH; otherwise depth is a single in-service flag.
module int_ack_ctrl
    import int_ack_ctrl_pkg::*;
#(
    parameter int unsigned ACK_CYCLES = 2,
    parameter int unsigned NEST_DEPTH = 3
) (
    input  logic           clk,
    input  logic           rst,
    int_ack_ctrl_if.slave  bus
);

`ifdef INT_ACK_CTRL_NEST_EN
    localparam bit NEST_ON = 1'b1;
`else
    localparam bit NEST_ON = 1'b0;
`endif

    localparam logic [INT_DEPTH_W-1:0] DEPTH_MAX =
        NEST_ON ? INT_DEPTH_W'(NEST_DEPTH) : INT_DEPTH_W'(1);
    localparam logic [ACK_CNT_W-1:0] ACK_LOAD = ACK_CNT_W'(ACK_CYCLES - 1);

    localparam logic [2:0] ST_IDLE   = 3'(IDLE);
    localparam logic [2:0] ST_PEND   = 3'(PEND);
    localparam logic [2:0] ST_TAKE   = 3'(TAKE);
    localparam logic [2:0] ST_ACK    = 3'(ACK);
    localparam logic [2:0] ST_SETTLE = 3'(SETTLE);

    logic                   irq_s;
    logic                   full;
    logic                   depth_inc;
    logic [2:0]             state_q,    state_d;
    logic [ACK_CNT_W-1:0]   cnt_q,      cnt_d;
    logic [INT_DEPTH_W-1:0] depth_q,    depth_d;
    logic                   take_q,     take_d;
    logic                   ack_q,      ack_d;
    logic                   iei_root_q, iei_root_d;

    sync2 u_irq_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.irq),
        .q   (irq_s)
    );

    assign full = (depth_q >= DEPTH_MAX);

    // Next state, shared ack/settle counter, depth and registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        depth_inc = 1'b0;
        depth_d   = depth_q;

        case (state_q)
            ST_IDLE: begin
                if (irq_s && bus.int_en && !full) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (!irq_s || !bus.int_en) state_d = ST_IDLE;
                else if (bus.boundary)     state_d = ST_TAKE;
            end
            ST_TAKE: begin
                if (bus.take_ack) begin
                    state_d = ST_ACK;
                    cnt_d   = ACK_LOAD;
                end
            end
            ST_ACK: begin
                if (cnt_q == '0) begin
                    state_d   = ST_SETTLE;
                    cnt_d     = ACK_CNT_W'(1);
                    depth_inc = 1'b1;
                end else begin
                    cnt_d = cnt_q - ACK_CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                // Two cycles let the synchronizer flush the cleared request.
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - ACK_CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // Coincident entry and ret cancel out.
        if (depth_inc && !bus.ret) begin
            if (!full) depth_d = depth_q + INT_DEPTH_W'(1);
        end else if (bus.ret && !depth_inc) begin
            if (depth_q != '0) depth_d = depth_q - INT_DEPTH_W'(1);
        end

        take_d     = (state_d == ST_TAKE);
        ack_d      = (state_d != ST_ACK);
        iei_root_d = (depth_d < DEPTH_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            depth_q    <= '0;
            take_q     <= 1'b0;
            ack_q      <= 1'b1;
            iei_root_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            depth_q    <= depth_d;
            take_q     <= take_d;
            ack_q      <= ack_d;
            iei_root_q <= iei_root_d;
        end
    end

    assign bus.take     = take_q;
    assign bus.ack      = ack_q;
    assign bus.iei_root = iei_root_q;
    assign bus.depth    = depth_q;

endmodule
